// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and sync-flag decode for the VGA display path.
// The font and display stages import this package so they agree on the geometry.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] coord_t;

  localparam coord_t COORD_ZERO = 10'd0;
  localparam coord_t COORD_ONE  = 10'd1;

  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } sync_flags_t;

  // Reset value matches the decode of the last pixel of a frame, so the state is consistent.
  localparam sync_flags_t SYNC_FLAGS_RST = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic sync_flags_t sync_flags(
    input coord_t px,
    input coord_t py,
    input coord_t h_disp,
    input coord_t hs_first,
    input coord_t hs_last,
    input coord_t v_disp,
    input coord_t vs_first,
    input coord_t vs_last
  );
    sync_flags_t f;
    f.video_on    = (px < h_disp) && (py < v_disp);
    f.hsync       = !((px >= hs_first) && (px <= hs_last));
    f.vsync       = !((py >= vs_first) && (py <= vs_last));
    f.line_start  = (px == COORD_ZERO);
    f.frame_start = (px == COORD_ZERO) && (py == COORD_ZERO);
    return f;
  endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Enabled modulo-M counter with programmable reset value and terminal-count strobe.
module mod_m_counter #(
  parameter int M       = 10,
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             max_tick
);

  localparam logic [WIDTH-1:0] LAST_VAL  = WIDTH'(M - 1);
  localparam logic [WIDTH-1:0] START_VAL = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ZERO_VAL  = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_VAL   = WIDTH'(1);

  logic [WIDTH-1:0] r_q;

  // Count register: wraps on an explicit compare to M-1 so it never reaches M.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= START_VAL;
    end else if (en) begin
      if (r_q == LAST_VAL) begin
        r_q <= ZERO_VAL;
      end else begin
        r_q <= r_q + ONE_VAL;
      end
    end
  end

  assign q        = r_q;
  assign max_tick = (r_q == LAST_VAL);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel strobe from a clock divider, x/y counters and
// registered blank/sync/start flags that switch on the same edge as x/y.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W = 4;

  localparam coord_t H_DISP_C   = coord_t'(H_DISPLAY);
  localparam coord_t HS_FIRST_C = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_LAST_C  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t V_DISP_C   = coord_t'(V_DISPLAY);
  localparam coord_t VS_FIRST_C = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_LAST_C  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] w_div_q_unused;
  logic             w_div_max;
  logic             w_x_max;
  logic             w_y_max;
  logic             w_y_en;
  coord_t           w_x;
  coord_t           w_y;
  coord_t           w_x_next;
  coord_t           w_y_next;
  sync_flags_t      w_flags_next;
  sync_flags_t      r_flags;

  // Reset parks x/y on the last pixel so the first strobe lands on (0,0).
  mod_m_counter #(
    .M       (CLK_DIV),
    .WIDTH   (DIV_W),
    .RST_VAL (0)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .en       (1'b1),
    .q        (w_div_q_unused),
    .max_tick (w_div_max)
  );

  mod_m_counter #(
    .M       (H_TOT),
    .WIDTH   (CNT_W),
    .RST_VAL (H_TOT - 1)
  ) u_x (
    .clk      (clk),
    .reset    (reset),
    .en       (w_div_max),
    .q        (w_x),
    .max_tick (w_x_max)
  );

  assign w_y_en = w_div_max & w_x_max;

  mod_m_counter #(
    .M       (V_TOT),
    .WIDTH   (CNT_W),
    .RST_VAL (V_TOT - 1)
  ) u_y (
    .clk      (clk),
    .reset    (reset),
    .en       (w_y_en),
    .q        (w_y),
    .max_tick (w_y_max)
  );

  // Position the counters will hold after the next pixel strobe.
  always_comb begin
    w_x_next = w_x;
    w_y_next = w_y;
    if (w_x_max) begin
      w_x_next = COORD_ZERO;
      if (w_y_max) begin
        w_y_next = COORD_ZERO;
      end else begin
        w_y_next = w_y + COORD_ONE;
      end
    end else begin
      w_x_next = w_x + COORD_ONE;
    end
  end

  assign w_flags_next = sync_flags(w_x_next, w_y_next, H_DISP_C, HS_FIRST_C, HS_LAST_C,
                                   V_DISP_C, VS_FIRST_C, VS_LAST_C);

  // Flags load on the strobe edge together with x/y, holding between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= SYNC_FLAGS_RST;
    end else if (w_div_max) begin
      r_flags <= w_flags_next;
    end
  end

  assign p_tick      = w_div_max;
  assign x           = w_x;
  assign y           = w_y;
  assign video_on    = r_flags.video_on;
  assign hsync       = r_flags.hsync;
  assign vsync       = r_flags.vsync;
  assign line_start  = r_flags.line_start;
  assign frame_start = r_flags.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three builds (default, CLK_DIV=1, small geometry) checked
// each cycle against a raster model derived from the clock count since reset release.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
  } obs_t;

  localparam int NI = 3;
  localparam int HD[NI]  = '{640, 640, 20};
  localparam int HF[NI]  = '{16, 16, 4};
  localparam int HS[NI]  = '{96, 96, 6};
  localparam int HB[NI]  = '{48, 48, 5};
  localparam int VD[NI]  = '{480, 480, 8};
  localparam int VF[NI]  = '{10, 10, 2};
  localparam int VS[NI]  = '{2, 2, 2};
  localparam int VB[NI]  = '{33, 33, 3};
  localparam int DIV[NI] = '{2, 1, 3};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pt[NI];
  logic [9:0] xs[NI];
  logic [9:0] ys[NI];
  logic       vo[NI];
  logic       hs[NI];
  logic       vs[NI];
  logic       ls[NI];
  logic       fs[NI];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_clk = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(.CLK_DIV(2)) dut_d (
    .clk(clk), .reset(reset), .p_tick(pt[0]), .x(xs[0]), .y(ys[0]), .video_on(vo[0]),
    .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_sync_gen #(.CLK_DIV(1)) dut_1 (
    .clk(clk), .reset(reset), .p_tick(pt[1]), .x(xs[1]), .y(ys[1]), .video_on(vo[1]),
    .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_sync_gen #(
    .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(3)
  ) dut_s (
    .clk(clk), .reset(reset), .p_tick(pt[2]), .x(xs[2]), .y(ys[2]), .video_on(vo[2]),
    .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  // Clock edges seen with reset low since the last reset.
  always @(posedge clk) begin
    if (reset) n_clk <= 0;
    else       n_clk <= n_clk + 1;
  end

  // Raster position = (strobes since release - 1) mod frame; flags decoded from it.
  function automatic obs_t model(input int i);
    obs_t e;
    int   ht, vt, fr, cnt, p, l, px, py;
    ht  = HD[i] + HF[i] + HS[i] + HB[i];
    vt  = VD[i] + VF[i] + VS[i] + VB[i];
    fr  = ht * vt;
    cnt = reset ? 0 : n_clk;
    p   = cnt / DIV[i];
    l   = (p + fr - 1) % fr;
    px  = l % ht;
    py  = l / ht;
    e.p_tick      = ((cnt % DIV[i]) == DIV[i] - 1);
    e.x           = 10'(px);
    e.y           = 10'(py);
    e.video_on    = (px < HD[i]) && (py < VD[i]);
    e.hsync       = !((px >= HD[i] + HF[i]) && (px < HD[i] + HF[i] + HS[i]));
    e.vsync       = !((py >= VD[i] + VF[i]) && (py < VD[i] + VF[i] + VS[i]));
    e.line_start  = (px == 0);
    e.frame_start = (px == 0) && (py == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    for (int i = 0; i < NI; i++) begin
      e = model(i);
      a = {pt[i], xs[i], ys[i], vo[i], hs[i], vs[i], ls[i], fs[i]};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL model[%0d] t=%0t actual pt=%b x=%0d y=%0d vo=%b hs=%b vs=%b ls=%b fs=%b required pt=%b x=%0d y=%0d vo=%b hs=%b vs=%b ls=%b fs=%b",
                 i, $time, a.p_tick, a.x, a.y, a.video_on, a.hsync, a.vsync, a.line_start, a.frame_start,
                 e.p_tick, e.x, e.y, e.video_on, e.hsync, e.vsync, e.line_start, e.frame_start);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic pulse_reset(input int hold, input int rel_ofs);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_now_x", xs[0], 799);
    chk("rst_now_y", ys[0], 524);
    chk("rst_now_hsync", hs[0], 1);
    chk("rst_now_video", vo[0], 0);
    repeat (hold) @(posedge clk);
    #(rel_ofs) reset = 1'b0;
  endtask

  initial begin
    int   hs_cnt, hs_first, vo_fall, vs_cnt, vs_x, vs_y, fs_t0, fs_t1;
    bit   vs_done;
    logic [9:0] px;
    logic pv, pvs, pfs;

    // Reset state and first strobe.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", xs[0], 799);
    chk("reset_y", ys[0], 524);
    chk("reset_hsync", hs[0], 1);
    chk("reset_vsync", vs[0], 1);
    chk("reset_video", vo[0], 0);
    chk("reset_fstart", fs[0], 0);
    chk("reset_small_x", xs[2], 34);
    chk("reset_small_y", ys[2], 14);
    chk("reset_div1_ptick", pt[1], 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("one_clk_x", xs[0], 799);
    chk("one_clk_div1_x", xs[1], 0);
    @(posedge clk);
    #1;
    chk("first_tick_x", xs[0], 0);
    chk("first_tick_y", ys[0], 0);
    chk("first_tick_video", vo[0], 1);
    chk("first_tick_lstart", ls[0], 1);
    chk("first_tick_fstart", fs[0], 1);

    // One line on the default build.
    hs_cnt = 0; hs_first = -1; vo_fall = -1;
    px = xs[0]; pv = vo[0];
    for (int k = 0; k < 1700; k++) begin
      @(negedge clk);
      if (xs[0] != px) begin
        if (!hs[0]) begin
          if (hs_cnt == 0) hs_first = int'(xs[0]);
          hs_cnt++;
        end
        if (pv && !vo[0] && vo_fall < 0) vo_fall = int'(xs[0]);
        px = xs[0];
        pv = vo[0];
      end
    end
    chk("hsync_low_len", hs_cnt, 96);
    chk("hsync_low_start", hs_first, 656);
    chk("video_fall_x", vo_fall, 640);

    // Frame behaviour on the small geometry build.
    pulse_reset(2, 3);
    vs_cnt = 0; vs_x = -1; vs_y = -1; vs_done = 1'b0; fs_t0 = -1; fs_t1 = -1;
    px = xs[2]; pvs = vs[2]; pfs = fs[2];
    for (int k = 0; k < 3300; k++) begin
      @(negedge clk);
      if (fs[2] && !pfs) begin
        if (fs_t0 < 0) fs_t0 = k;
        else if (fs_t1 < 0) fs_t1 = k;
      end
      if (xs[2] != px && !vs_done) begin
        if (!vs[2]) begin
          if (vs_cnt == 0) begin
            vs_x = int'(xs[2]);
            vs_y = int'(ys[2]);
          end
          vs_cnt++;
        end else if (!pvs) begin
          vs_done = 1'b1;
        end
        pvs = vs[2];
      end
      px = xs[2];
      pfs = fs[2];
    end
    chk("vsync_low_pixels", vs_cnt, 70);
    chk("vsync_start_x", vs_x, 0);
    chk("vsync_start_y", vs_y, 10);
    chk("frame_period_clk", fs_t1 - fs_t0, 1575);

    // Mid-line reset at x=300 held for three clocks, then restart.
    pulse_reset(2, 1);
    begin
      int k;
      k = 0;
      while (xs[0] != 10'd300 && k < 2000) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    chk("reach_x300", xs[0], 300);
    reset = 1'b1;
    #1;
    chk("midreset_x", xs[0], 799);
    chk("midreset_y", ys[0], 524);
    chk("midreset_vsync", vs[0], 1);
    chk("midreset_lstart", ls[0], 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("restart_x", xs[0], 0);
    chk("restart_fstart", fs[0], 1);

    // Random run lengths and reset pulses, checked by the per-cycle model.
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(50, 2500)) @(posedge clk);
      pulse_reset($urandom_range(1, 4), $urandom_range(1, 8));
    end
    repeat (400) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
